// File: rtl/ros2_rx_msg_capture_pkg.sv
// ---------------------------------------------------------------------------
// ros2_rx_capture_pkg
// Shared types and constants for the ROS2 received-message capture block.
//   cap_state_t   : capture FSM states (IDLE, RECV, COMMIT)
//   BANKS         : number of ping-pong byte banks
//   gap_cnt_width : width of a down-counter that must hold gap_cycles
// ---------------------------------------------------------------------------
package ros2_rx_capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } cap_state_t;

    // Ping-pong pair: one bank is filled while the other is visible to readers.
    localparam int BANKS = 2;

    // Width of the idle-gap counter.
    function automatic int gap_cnt_width(input int gap_cycles);
        return $clog2(gap_cycles + 1);
    endfunction

endpackage

// File: rtl/ros2_rx_bank_ram.sv
// ---------------------------------------------------------------------------
// ros2_rx_bank_ram
// Two DEPTH x 8 byte banks sharing one storage array, addressed as
// {bank, addr}. One synchronous write port, one registered read port.
// Ports:
//   clk, rst_n          : clock, async active-low reset (read register only)
//   we, wr_bank,
//   wr_addr, wr_data    : write port
//   rd_bank, rd_addr    : read address, sampled every cycle
//   rd_data             : registered read data, 1-cycle latency
// A read and a write to the same location in the same cycle return the old
// byte.
// ---------------------------------------------------------------------------
module ros2_rx_bank_ram
    import ros2_rx_capture_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [DW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_bank,
    input  logic [DW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [BANKS*DEPTH];

    // NOTE: storage has no reset so it maps onto RAM primitives; only the
    // output register is reset, and unwritten locations read as don't-care.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments on all clocked state, so every process
    // sees pre-edge values and same-address read/write returns the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/ros2_rx_msg_capture.sv
// ---------------------------------------------------------------------------
// ros2_rx_msg_capture
// Captures each message from the ROS2 subscriber write port into a ping-pong
// bank, detects end-of-message by an idle gap, then commits the bank
// atomically so readers and LED logic never see a half-written message.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   wr_addr, wr_ce, wr_we, wr_data     : subscriber byte write port
//   rx_len                             : message length from subscriber
//   rd_addr / rd_data                  : read of committed bank, 1-cycle latency
//   msg_len                            : min(rx_len, DEPTH) of committed message
//   msg_count                          : committed-message counter (mod 2^16)
//   msg_valid                          : 1-cycle pulse in the commit cycle
//   ovf_err                            : sticky address / length overflow
//   led_act                            : commit indicator stretched LED_HOLD cycles
//   led_nib                            : bits [3:0] of committed byte 0
// ---------------------------------------------------------------------------
module ros2_rx_msg_capture
    import ros2_rx_capture_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int AW         = $clog2(DEPTH),
    parameter int GAP_CYCLES = 16,
    parameter int LED_HOLD   = 12500000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_ce,
    input  logic          wr_we,
    input  logic [7:0]    wr_data,
    input  logic [7:0]    rx_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [7:0]    msg_len,
    output logic [15:0]   msg_count,
    output logic          msg_valid,
    output logic          ovf_err,
    output logic          led_act,
    output logic [3:0]    led_nib
);

    localparam int DW = $clog2(DEPTH);
    localparam int GW = gap_cnt_width(GAP_CYCLES);
    localparam int LW = $clog2(LED_HOLD + 1);

    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LED_RELOAD = LW'(LED_HOLD);
    localparam logic [7:0]    LEN_MAX    = 8'(DEPTH);

    cap_state_t    state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic [LW-1:0] led_cnt;
    logic          wr_bank;       // committed bank is always ~wr_bank
    logic [3:0]    byte0_nib;     // shadow of write-bank byte 0, low nibble
    logic          wr_fire;
    logic          addr_ok;
    logic          ram_we;
    logic          ram_wr_bank;
    logic          commit;
    logic          len_over;

    assign wr_fire = wr_ce & wr_we;

    // Out-of-range addresses only exist when the port is wider than a bank.
    if (AW > DW) begin : g_wide_addr
        assign addr_ok = (wr_addr[AW-1:DW] == '0);
    end else begin : g_exact_addr
        assign addr_ok = 1'b1;
    end

    assign commit    = (state == COMMIT);
    assign msg_valid = commit;
    assign len_over  = (32'(rx_len) > 32'(DEPTH));
    assign ram_we    = wr_fire & addr_ok;

    // A write in the commit cycle starts the next message, so it must go to
    // the bank that becomes the write bank at the end of this cycle.
    assign ram_wr_bank = commit ? ~wr_bank : wr_bank;

    // ---------------------------------------------------------------- FSM
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        if (wr_fire) begin
            // A write always wins, including against an expiring gap counter.
            state_nxt   = RECV;
            gap_cnt_nxt = GAP_RELOAD;
        end else begin
            unique case (state)
                RECV: begin
                    if (gap_cnt == '0) begin
                        state_nxt = COMMIT;
                    end else begin
                        gap_cnt_nxt = gap_cnt - 1'b1;
                    end
                end
                COMMIT:  state_nxt = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // ------------------------------------------------ commit-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            byte0_nib <= '0;
            msg_len   <= '0;
            msg_count <= '0;
            ovf_err   <= 1'b0;
            led_nib   <= '0;
            led_cnt   <= '0;
        end else begin
            if (ram_we && (wr_addr[DW-1:0] == '0)) begin
                byte0_nib <= wr_data[3:0];
            end

            if ((wr_fire && !addr_ok) || (commit && len_over)) begin
                ovf_err <= 1'b1;
            end

            if (commit) begin
                wr_bank   <= ~wr_bank;
                msg_len   <= len_over ? LEN_MAX : rx_len;
                msg_count <= msg_count + 16'd1;
                led_nib   <= byte0_nib;   // pre-update value: excludes a same-cycle write
                led_cnt   <= LED_RELOAD;  // reload, never accumulate
            end else if (led_cnt != '0) begin
                led_cnt <= led_cnt - 1'b1;
            end
        end
    end

    assign led_act = (led_cnt != '0);

    // ------------------------------------------------------------ storage
    ros2_rx_bank_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_bank_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .wr_bank (ram_wr_bank),
        .wr_addr (wr_addr[DW-1:0]),
        .wr_data (wr_data),
        .rd_bank (~wr_bank),
        .rd_addr (rd_addr[DW-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ros2_rx_msg_capture.sv
// ---------------------------------------------------------------------------
// tb_ros2_rx_msg_capture
// Scoreboard bench: each message's expected commit results are queued when
// its bytes are driven and compared when the DUT pulses msg_valid.
// Inputs change and outputs are sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_ros2_rx_msg_capture;

    localparam int DEPTH = 64;
    localparam int AW    = 7;    // one bit wider than a bank, to reach >= DEPTH
    localparam int GAP   = 8;
    localparam int HOLD  = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] wr_addr;
    logic          wr_ce;
    logic          wr_we;
    logic [7:0]    wr_data;
    logic [7:0]    rx_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    msg_len;
    logic [15:0]   msg_count;
    logic          msg_valid;
    logic          ovf_err;
    logic          led_act;
    logic [3:0]    led_nib;

    ros2_rx_msg_capture #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .GAP_CYCLES (GAP),
        .LED_HOLD   (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_addr   (wr_addr),
        .wr_ce     (wr_ce),
        .wr_we     (wr_we),
        .wr_data   (wr_data),
        .rx_len    (rx_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .msg_len   (msg_len),
        .msg_count (msg_count),
        .msg_valid (msg_valid),
        .ovf_err   (ovf_err),
        .led_act   (led_act),
        .led_nib   (led_nib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  len;
        logic [15:0] count;
        logic [3:0]  nib;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          valid_pulses = 0;
    logic [15:0] exp_count;
    logic        exp_ovf;

    // Counted at the rising edge, before state moves on.
    always @(posedge clk) if (msg_valid === 1'b1) valid_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue the expected commit results for a message with this rx_len and byte 0.
    task automatic push_msg(input int len, input logic [7:0] byte0);
        exp_t e;
        exp_count = exp_count + 16'd1;
        if (len > DEPTH) exp_ovf = 1'b1;
        e.len   = (len > DEPTH) ? 8'(DEPTH) : 8'(len);
        e.count = exp_count;
        e.nib   = byte0[3:0];
        e.ovf   = exp_ovf;
        sb.push_back(e);
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [7:0] d);
        wr_ce   = 1'b1;
        wr_we   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_ce   = 1'b0;
        wr_we   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"},   rd_data,   0);
        check({tag, "_msg_len"},   msg_len,   0);
        check({tag, "_msg_count"}, msg_count, 0);
        check({tag, "_msg_valid"}, msg_valid, 0);
        check({tag, "_ovf_err"},   ovf_err,   0);
        check({tag, "_led_act"},   led_act,   0);
        check({tag, "_led_nib"},   led_nib,   0);
    endtask

    // Wait (bounded) for msg_valid. exp_lat counts the current cycle as 1.
    // Optionally drive one write in the commit cycle. Returns one cycle after
    // the commit, when the committed outputs have updated.
    task automatic expect_commit(input string tag, input int exp_lat,
                                 input bit coll, input logic [AW-1:0] ca,
                                 input logic [7:0] cd);
        int   k    = 1;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && k <= 40) begin
            if (msg_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, "_seen"}, 32'(seen), 1);
        if (seen) begin
            check({tag, "_latency"}, k, exp_lat);
            if (coll) drive_write(ca, cd);
            else      @(negedge clk);
            check({tag, "_pulse_end"}, msg_valid, 0);
        end
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_msg_len"},   msg_len,   e.len);
            check({tag, "_msg_count"}, msg_count, e.count);
            check({tag, "_led_nib"},   led_nib,   e.nib);
            check({tag, "_ovf_err"},   ovf_err,   e.ovf);
            check({tag, "_led_act"},   led_act,   1);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] t2_data [4];
        int         p0;
        int         n_led;

        rst_n   = 1'b0;
        wr_addr = '0;
        wr_ce   = 1'b0;
        wr_we   = 1'b0;
        wr_data = '0;
        rx_len  = '0;
        rd_addr = '0;
        exp_count = '0;
        exp_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // --- T1: "ABC" then idle: commit 9 cycles after the last write.
        rx_len = 8'd3;
        push_msg(3, 8'h41);
        drive_write(0, 8'h41);
        drive_write(1, 8'h42);
        drive_write(2, 8'h43);
        expect_commit("t1", 9, 1'b0, '0, '0);
        read_check("t1_rd1", 1, 8'h42);
        read_check("t1_rd0", 0, 8'h41);
        read_check("t1_rd2", 2, 8'h43);

        // --- T2: writes 7 idle cycles apart never end the message.
        t2_data = '{8'h10, 8'h21, 8'h32, 8'h43};
        rx_len  = 8'd4;
        push_msg(4, t2_data[0]);
        p0 = valid_pulses;
        for (int i = 0; i < 4; i++) begin
            drive_write(AW'(i), t2_data[i]);
            if (i < 3) repeat (GAP - 1) @(negedge clk);
        end
        check("t2_no_early_commit", valid_pulses - p0, 0);
        expect_commit("t2", 9, 1'b0, '0, '0);
        check("t2_single_pulse", valid_pulses - p0, 1);
        for (int i = 0; i < 4; i++) read_check("t2_rd", AW'(i), t2_data[i]);

        // --- T3: write in commit cycle belongs to the next message; reads of
        // addr 0 see the old bank through the commit cycle.
        rd_addr = '0;
        rx_len  = 8'd2;
        push_msg(2, 8'hA5);   // message A
        push_msg(2, 8'h3C);   // message B, starts in A's commit cycle
        drive_write(0, 8'hA5);
        drive_write(1, 8'h5A);
        expect_commit("t3a", 9, 1'b1, 0, 8'h3C);
        check("t3_swap_old", rd_data, 8'h10);
        drive_write(1, 8'h77);
        check("t3_swap_new", rd_data, 8'hA5);
        read_check("t3a_rd1", 1, 8'h5A);
        expect_commit("t3b", 8, 1'b0, '0, '0);
        read_check("t3b_rd0", 0, 8'h3C);
        read_check("t3b_rd1", 1, 8'h77);

        // --- T4: rx_len overflow clamps and sets a sticky error.
        rx_len = 8'd200;
        push_msg(200, 8'h9E);
        drive_write(0, 8'h9E);
        expect_commit("t4_ovf", 9, 1'b0, '0, '0);
        rx_len = 8'd5;
        push_msg(5, 8'h07);
        drive_write(0, 8'h07);
        expect_commit("t4_sticky", 9, 1'b0, '0, '0);

        // Counter wrap: preset 0xFFFF, next commit must read 0x0000.
        force dut.msg_count = 16'hFFFF;
        @(negedge clk);
        release dut.msg_count;
        @(negedge clk);
        check("t4_count_preset", msg_count, 16'hFFFF);
        exp_count = 16'hFFFF;
        rx_len = 8'd1;
        push_msg(1, 8'h22);
        drive_write(0, 8'h22);
        expect_commit("t4_wrap", 9, 1'b0, '0, '0);

        // --- T5: reset mid-message discards it and clears outputs.
        rx_len = 8'd5;
        drive_write(0, 8'h55);
        drive_write(1, 8'h66);
        p0 = valid_pulses;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_commit", valid_pulses - p0, 0);
        check("t5_count_idle", msg_count, 0);
        exp_count = '0;
        exp_ovf   = 1'b0;
        push_msg(5, 8'h31);
        for (int i = 0; i < 5; i++) drive_write(AW'(i), 8'h31 + 8'(i));
        expect_commit("t5", 9, 1'b0, '0, '0);
        n_led = 0;
        while (led_act === 1'b1 && n_led < 20) begin
            n_led++;
            @(negedge clk);
        end
        check("t5_led_hold", n_led, HOLD);
        read_check("t5_rd4", 4, 8'h35);

        // --- T6: address >= DEPTH is dropped and sets ovf_err.
        rx_len = 8'd7;
        exp_ovf = 1'b1;
        push_msg(7, 8'h12);
        drive_write(0, 8'h12);
        drive_write(6, 8'h66);
        drive_write(70, 8'hEE);
        check("t6_addr_ovf", ovf_err, 1);
        drive_write(1, 8'h13);
        expect_commit("t6", 9, 1'b0, '0, '0);
        read_check("t6_rd6", 6, 8'h66);
        read_check("t6_rd0", 0, 8'h12);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
